// File: rtl/hazard_sequencer.sv
// Pipeline hazard unit: operand forwarding, load-use and branch handling, and a
// memory-wait FSM with timeout, sticky error flag and a saturating stall counter.
module hazard_sequencer #(
    parameter int unsigned WAIT_LIMIT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  RS1D,
    input  logic [4:0]  RS2D,
    input  logic [4:0]  RS1E,
    input  logic [4:0]  RS2E,
    input  logic [4:0]  RDE,
    input  logic        ResultSrcE,
    input  logic        PCSrcE,
    input  logic        RegWriteM,
    input  logic [4:0]  RdM,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic        MemReqM,
    input  logic        MemAckM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        MemErr,
    output logic [15:0] StallCount
);

    typedef enum logic {StRun, StMemWait} state_e;

    state_e      state_q;
    logic [7:0]  wait_cnt_q;
    logic        mem_err_q;
    logic [15:0] stall_cnt_q;

    logic       mem_stall;
    logic       lduse;
    logic       timeout;
    logic       stall_all;
    logic       stall_fd;
    logic       flush_d;
    logic       flush_e;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    // Memory stage result is newer than Writeback, so it wins.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wr_m,
                                           input logic [4:0] rd_m, input logic wr_w,
                                           input logic [4:0] rd_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != 5'd0) begin
            if (wr_m && rd_m == rs) begin
                sel = 2'b10;
            end else if (wr_w && rd_w == rs) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    assign fwd_a = fwd_sel(RS1E, RegWriteM, RdM, RegWriteW, RdW);
    assign fwd_b = fwd_sel(RS2E, RegWriteM, RdM, RegWriteW, RdW);

    assign mem_stall = MemReqM & ~MemAckM;
    assign lduse     = ResultSrcE && (RDE != 5'd0) && ((RDE == RS1D) || (RDE == RS2D));
    // This cycle would be the WAIT_LIMIT-th stalled cycle of the access.
    assign timeout   = (32'(wait_cnt_q) + 32'd1) >= WAIT_LIMIT;

    always_comb begin
        stall_all = 1'b0;
        stall_fd  = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        case (state_q)
            StRun: begin
                if (mem_stall) begin
                    stall_all = 1'b1;
                end else if (PCSrcE) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (lduse) begin
                    stall_fd = 1'b1;
                    flush_e  = 1'b1;
                end
            end
            StMemWait: begin
                if (!MemAckM && !timeout) begin
                    stall_all = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Reset forces every control output low regardless of state or inputs.
    assign StallF    = reset & (stall_all | stall_fd);
    assign StallD    = reset & (stall_all | stall_fd);
    assign StallE    = reset & stall_all;
    assign StallM    = reset & stall_all;
    assign FlushD    = reset & flush_d;
    assign FlushE    = reset & flush_e;
    assign ForwardAE = reset ? fwd_a : 2'b00;
    assign ForwardBE = reset ? fwd_b : 2'b00;
    assign MemErr     = mem_err_q;
    assign StallCount = stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StRun;
            wait_cnt_q  <= 8'd0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            if (StallF && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            case (state_q)
                StRun: begin
                    if (mem_stall) begin
                        state_q    <= StMemWait;
                        wait_cnt_q <= 8'd1;
                    end
                end
                StMemWait: begin
                    if (MemAckM) begin
                        state_q    <= StRun;
                        wait_cnt_q <= 8'd0;
                    end else if (timeout) begin
                        state_q    <= StRun;
                        wait_cnt_q <= 8'd0;
                        mem_err_q  <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer with WAIT_LIMIT=4; expected values hand-computed.
module tb_hazard_sequencer;

    logic        clk;
    logic        reset;
    logic [4:0]  RS1D, RS2D, RS1E, RS2E, RDE, RdM, RdW;
    logic        ResultSrcE, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemAckM;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, MemErr;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [15:0] StallCount;

    int total = 0;
    int bad   = 0;

    hazard_sequencer #(.WAIT_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .RS1D(RS1D), .RS2D(RS2D), .RS1E(RS1E), .RS2E(RS2E), .RDE(RDE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RegWriteM(RegWriteM), .RdM(RdM), .RegWriteW(RegWriteW), .RdW(RdW),
        .MemReqM(MemReqM), .MemAckM(MemAckM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemErr(MemErr), .StallCount(StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // {StallF, StallD, StallE, StallM, FlushD, FlushE}
    function automatic logic [15:0] ctl();
        return {10'd0, StallF, StallD, StallE, StallM, FlushD, FlushE};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        RS1D = 0; RS2D = 0; RS1E = 0; RS2E = 0; RDE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
        MemReqM = 0; MemAckM = 0;
    endtask

    initial begin
        // Reset with hostile inputs: everything must read zero.
        reset = 1'b0;
        clear_inputs();
        RegWriteM = 1; RdM = 5; RS1E = 5; RS2E = 5; MemReqM = 1; PCSrcE = 1;
        ResultSrcE = 1; RDE = 3; RS1D = 3;
        tick(); tick();
        chk("rst_ctl", ctl(), 16'h0000);
        chk("rst_fwda", 16'(ForwardAE), 16'h0);
        chk("rst_fwdb", 16'(ForwardBE), 16'h0);
        chk("rst_err", 16'(MemErr), 16'h0);
        chk("rst_cnt", StallCount, 16'd0);

        clear_inputs();
        reset = 1'b1;
        tick();

        // Forwarding priority and register 0.
        RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; RS1E = 5; RS2E = 0;
        #1;
        chk("fwd_m_a", 16'(ForwardAE), 16'h2);
        chk("fwd_m_b", 16'(ForwardBE), 16'h0);
        chk("fwd_ctl", ctl(), 16'h0000);
        RegWriteM = 0; RdM = 7; RdW = 7; RS1E = 7; RS2E = 7;
        #1;
        chk("fwd_w_a", 16'(ForwardAE), 16'h1);
        chk("fwd_w_b", 16'(ForwardBE), 16'h1);
        RegWriteM = 1; RdM = 0; RdW = 0; RS1E = 0; RS2E = 0;
        #1;
        chk("fwd_x0_a", 16'(ForwardAE), 16'h0);
        chk("fwd_x0_b", 16'(ForwardBE), 16'h0);
        clear_inputs();

        // Load-use: one cycle stall, then the bubble clears the hazard.
        ResultSrcE = 1; RDE = 3; RS2D = 3;
        #1;
        chk("lduse_ctl", ctl(), 16'b110001);
        tick();
        ResultSrcE = 0; RDE = 0;
        #1;
        chk("lduse_after", ctl(), 16'h0000);
        chk("lduse_cnt", StallCount, 16'd1);

        // Load into x0 is not a hazard.
        ResultSrcE = 1; RDE = 0; RS1D = 0; RS2D = 0;
        #1;
        chk("lduse_x0", ctl(), 16'h0000);

        // Taken branch overrides load-use.
        RDE = 3; RS2D = 3; PCSrcE = 1;
        #1;
        chk("br_ctl", ctl(), 16'b000011);
        tick();
        clear_inputs();
        #1;
        chk("br_cnt", StallCount, 16'd1);

        // Memory wait: 3 stalled cycles, ack releases.
        MemReqM = 1;
        #1;
        chk("mw_c1", ctl(), 16'b111100);
        tick();
        PCSrcE = 1; ResultSrcE = 1; RDE = 3; RS2D = 3;
        #1;
        chk("mw_c2_ign", ctl(), 16'b111100);
        tick();
        PCSrcE = 0; ResultSrcE = 0; RDE = 0; RS2D = 0;
        #1;
        chk("mw_c3", ctl(), 16'b111100);
        tick();
        MemAckM = 1;
        #1;
        chk("mw_ack", ctl(), 16'h0000);
        tick();
        MemReqM = 0; MemAckM = 0; PCSrcE = 1;
        #1;
        chk("mw_run", ctl(), 16'b000011);
        chk("mw_cnt", StallCount, 16'd4);
        chk("mw_err", 16'(MemErr), 16'h0);
        tick();

        // Request with ack in the same cycle: no stall.
        PCSrcE = 0; MemReqM = 1; MemAckM = 1;
        #1;
        chk("zw_ctl", ctl(), 16'h0000);
        tick();
        MemReqM = 0; MemAckM = 0; PCSrcE = 1;
        #1;
        chk("zw_run", ctl(), 16'b000011);
        chk("zw_cnt", StallCount, 16'd4);
        tick();

        // Timeout at WAIT_LIMIT=4: stall 3 cycles, release on the 4th, MemErr sticks.
        PCSrcE = 0; MemReqM = 1;
        #1;
        chk("to_c1", ctl(), 16'b111100);
        tick();
        chk("to_c2", ctl(), 16'b111100);
        tick();
        chk("to_c3", ctl(), 16'b111100);
        tick();
        chk("to_c4", ctl(), 16'h0000);
        chk("to_err_pre", 16'(MemErr), 16'h0);
        tick();
        MemReqM = 0; PCSrcE = 1;
        #1;
        chk("to_err", 16'(MemErr), 16'h1);
        chk("to_run", ctl(), 16'b000011);
        chk("to_cnt", StallCount, 16'd7);
        tick();

        // Operation continues with MemErr set.
        PCSrcE = 0; ResultSrcE = 1; RDE = 4; RS1D = 4;
        #1;
        chk("post_lduse", ctl(), 16'b110001);
        tick();
        clear_inputs();
        #1;
        chk("post_cnt", StallCount, 16'd8);
        chk("post_err", 16'(MemErr), 16'h1);

        // Reset in the middle of a memory wait aborts it at once.
        MemReqM = 1;
        tick();
        tick();
        chk("rw_stall", ctl(), 16'b111100);
        RegWriteM = 1; RdM = 9; RS1E = 9;
        reset = 1'b0;
        #1;
        chk("rw_ctl", ctl(), 16'h0000);
        chk("rw_fwd", 16'(ForwardAE), 16'h0);
        chk("rw_err", 16'(MemErr), 16'h0);
        chk("rw_cnt", StallCount, 16'd0);
        tick();
        clear_inputs();
        reset = 1'b1;
        PCSrcE = 1;
        #1;
        chk("rw_run", ctl(), 16'b000011);
        tick();
        chk("rw_err2", 16'(MemErr), 16'h0);
        chk("rw_cnt2", StallCount, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
